// File: rtl/sram_req_bridge.sv
// sram_req_bridge: request/response front end for the single-port SRAM macro.
// All macro pins (csb0/web0/addr0/din0) are registered; one request in flight.
// Byte-masked writes are done as read-modify-write.
//   clk0, rst_n          clock (shared with macro), async active-low reset
//   req_*                valid/ready request channel (we, addr, wdata, wmask)
//   rsp_*                valid/ready read-response channel (rdata)
//   csb0, web0, addr0,   macro command pins
//   din0, dout0          macro data pins
module sram_req_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    WR_ISSUE,
    RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR_FULL,
    OP_WR_PART
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic                  csb_d, web_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [DATA_WIDTH-1:0] merged;

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);

  for (genvar g = 0; g < MASK_WIDTH; g++) begin : g_merge
    assign merged[g*8 +: 8] = mask_q[g] ? wdata_q[g*8 +: 8] : dout0[g*8 +: 8];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    addr_d      = addr0;
    din_d       = din0;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          wdata_d = req_wdata;
          mask_d  = req_wmask;
          if (!req_we) begin
            op_d    = OP_RD;
            csb_d   = 1'b0;
            addr_d  = req_addr;
            state_d = ISSUE;
          end else if (req_wmask == '1) begin
            op_d    = OP_WR_FULL;
            csb_d   = 1'b0;
            web_d   = 1'b0;
            addr_d  = req_addr;
            din_d   = req_wdata;
            state_d = ISSUE;
          end else if (req_wmask != '0) begin
            // Partial write starts with a read of the target word.
            op_d    = OP_WR_PART;
            csb_d   = 1'b0;
            addr_d  = req_addr;
            state_d = ISSUE;
          end
          // Zero-mask write: accepted and dropped, no macro access.
        end
      end

      ISSUE: begin
        state_d = (op_q == OP_WR_FULL) ? IDLE : CAPT;
      end

      CAPT: begin
        if (op_q == OP_RD) begin
          rsp_rdata_d = dout0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          din_d   = merged;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          state_d = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        state_d = IDLE;
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_RD;
      wdata_q   <= '0;
      mask_q    <= '0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      addr0     <= '0;
      din0      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      csb0      <= csb_d;
      web0      <= web_d;
      addr0     <= addr_d;
      din0      <= din_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_req_bridge.sv
`timescale 1ns/1ps
module tb_sram_req_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned MW = DW / 8;

  logic          clk0 = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [MW-1:0] req_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  always #5 clk0 = ~clk0;

  sram_req_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0(clk0), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          cmd_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] sram    [0:127];
  int unsigned   t_acc[$];
  int unsigned   cyc = 0;

  // Behavioural macro: command sampled at posedge, write/read resolved at negedge.
  cmd_t          mc;
  logic          pend = 1'b0;
  logic          pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_din;

  always @(posedge clk0) begin
    cyc++;
    if (csb0 === 1'b0) begin
      t_acc.push_back(cyc);
      check("sram_cmd_expected", 64'(cmd_q.size() > 0), 64'd1);
      if (cmd_q.size() > 0) begin
        mc = cmd_q.pop_front();
        check("sram_we", 64'(web0 === 1'b0), 64'(mc.we));
        check("sram_addr", 64'(addr0), 64'(mc.addr));
        if (mc.we) check("sram_din", 64'(din0), 64'(mc.data));
      end
      pend      = 1'b1;
      pend_we   = (web0 === 1'b0);
      pend_addr = addr0;
      pend_din  = din0;
    end
  end

  always @(negedge clk0) begin
    if (pend) begin
      if (pend_we) sram[pend_addr] = pend_din;
      else         dout0 <= sram[pend_addr];
      pend = 1'b0;
    end
  end

  // Pin discipline: csb0 low one cycle at a time, addr0/din0 move only as csb0 falls.
  logic          prev_ok = 1'b0;
  logic          prev_csb;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_din;

  always @(negedge clk0) begin
    if (rst_n && prev_ok) begin
      if (!(prev_csb === 1'b1 && csb0 === 1'b0)) begin
        check("addr0_stable", 64'(addr0), 64'(prev_addr));
        check("din0_stable", 64'(din0), 64'(prev_din));
      end
      if (prev_csb === 1'b0) check("csb0_single_cycle", 64'(csb0), 64'd1);
    end
    prev_ok   = rst_n;
    prev_csb  = csb0;
    prev_addr = addr0;
    prev_din  = din0;
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old_w;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Presents one request, waits for acceptance, records the accept edge and
  // pushes the expected macro commands / response.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] m, output int unsigned t0);
    int unsigned n = 0;
    logic [DW-1:0] nw;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    @(negedge clk0);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk0);
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    @(posedge clk0);
    #1;
    req_valid = 1'b0;
    t0 = cyc;
    if (!we) begin
      cmd_q.push_back('{we: 1'b0, addr: a, data: '0});
      rsp_q.push_back(ref_mem[a]);
    end else if (m == '1) begin
      cmd_q.push_back('{we: 1'b1, addr: a, data: d});
      ref_mem[a] = d;
    end else if (m != '0) begin
      nw = merge(ref_mem[a], d, m);
      cmd_q.push_back('{we: 1'b0, addr: a, data: '0});
      cmd_q.push_back('{we: 1'b1, addr: a, data: nw});
      ref_mem[a] = nw;
    end
  endtask

  task automatic recv(input int unsigned t0);
    int unsigned n = 0;
    logic [DW-1:0] e;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk0);
      #1;
      n++;
    end
    check("rsp_valid_seen", 64'(rsp_valid === 1'b1), 64'd1);
    check("rsp_latency", 64'(cyc - t0), 64'd2);
    e = (rsp_q.size() > 0) ? rsp_q.pop_front() : 'x;
    check("rsp_rdata", 64'(rsp_rdata), 64'(e));
    @(posedge clk0);
    #1;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check("req_ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  task automatic wr_full(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned t0;
    send(1'b1, a, d, '1, t0);
    @(posedge clk0);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    int unsigned t0;
    send(1'b0, a, '0, '0, t0);
    recv(t0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned n0;
    logic [DW-1:0] held;
    logic [DW-1:0] saved;

    // Reset held with a request pending.
    #1 rst_n = 1'b0;
    req_valid = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    check("rst_csb0", 64'(csb0), 64'd1);
    check("rst_web0", 64'(web0), 64'd1);
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_din0", 64'(din0), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    @(negedge clk0);
    #2 rst_n = 1'b1;
    @(posedge clk0);
    #1;
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_csb0", 64'(csb0), 64'd1);

    // Full write then read-back.
    send(1'b1, 7'h05, 32'hDEADBEEF, 4'hF, t0);
    check("fw_csb0_low", 64'(csb0), 64'd0);
    check("fw_web0_low", 64'(web0), 64'd0);
    check("fw_busy", 64'(req_ready), 64'd0);
    @(posedge clk0);
    #1;
    check("fw_csb0_high", 64'(csb0), 64'd1);
    check("fw_ready_again", 64'(req_ready), 64'd1);
    send(1'b0, 7'h05, '0, '0, t0);
    check("rd_csb0_low", 64'(csb0), 64'd0);
    check("rd_web0_high", 64'(web0), 64'd1);
    recv(t0);

    // Partial write via read-modify-write.
    wr_full(7'h7F, 32'h11223344);
    n0 = t_acc.size();
    send(1'b1, 7'h7F, 32'hAABBCCDD, 4'h5, t0);
    check("pw_busy0", 64'(req_ready), 64'd0);
    @(posedge clk0);
    #1;
    check("pw_busy1", 64'(req_ready), 64'd0);
    @(posedge clk0);
    #1;
    check("pw_busy2", 64'(req_ready), 64'd0);
    @(posedge clk0);
    #1;
    check("pw_ready_again", 64'(req_ready), 64'd1);
    check("pw_access_count", 64'(t_acc.size() - n0), 64'd2);
    if (t_acc.size() >= n0 + 2) begin
      check("pw_read_edge", 64'(t_acc[n0] - t0), 64'd1);
      check("pw_write_edge", 64'(t_acc[n0+1] - t0), 64'd3);
    end
    rd(7'h7F);

    // Response back-pressure.
    wr_full(7'h00, 32'hCAFEF00D);
    rsp_ready = 1'b0;
    send(1'b0, 7'h00, '0, '0, t0);
    n0 = 0;
    while (rsp_valid !== 1'b1 && n0 < 20) begin
      @(posedge clk0);
      #1;
      n0++;
    end
    check("bp_latency", 64'(cyc - t0), 64'd2);
    held = (rsp_q.size() > 0) ? rsp_q.pop_front() : 'x;
    check("bp_rdata", 64'(rsp_rdata), 64'(held));
    n0 = t_acc.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk0);
      #1;
      check("bp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_rdata_stable", 64'(rsp_rdata), 64'(held));
      check("bp_req_stalled", 64'(req_ready), 64'd0);
      check("bp_csb0_idle", 64'(csb0), 64'd1);
    end
    check("bp_no_access", 64'(t_acc.size()), 64'(n0));
    rsp_ready = 1'b1;
    @(posedge clk0);
    #1;
    check("bp_valid_drop", 64'(rsp_valid), 64'd0);
    check("bp_req_ready", 64'(req_ready), 64'd1);

    // Zero-mask write and boundary addresses.
    wr_full(7'h10, 32'h0BADF00D);
    n0 = t_acc.size();
    send(1'b1, 7'h10, 32'hFFFFFFFF, 4'h0, t0);
    check("mz_stay_idle", 64'(req_ready), 64'd1);
    check("mz_csb0", 64'(csb0), 64'd1);
    repeat (2) @(posedge clk0);
    #1;
    check("mz_no_access", 64'(t_acc.size()), 64'(n0));
    rd(7'h10);
    rd(7'h00);
    rd(7'h7F);

    // Async reset while the RMW sits in CAPT.
    wr_full(7'h20, 32'h55667788);
    saved = ref_mem[7'h20];
    send(1'b1, 7'h20, 32'h00000000, 4'h3, t0);
    @(posedge clk0);
    #1;
    check("rr_in_capt_csb0", 64'(csb0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_csb0", 64'(csb0), 64'd1);
    check("rr_web0", 64'(web0), 64'd1);
    check("rr_addr0", 64'(addr0), 64'd0);
    check("rr_din0", 64'(din0), 64'd0);
    check("rr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rr_req_ready", 64'(req_ready), 64'd0);
    cmd_q.delete();
    ref_mem[7'h20] = saved;
    n0 = t_acc.size();
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk0);
      #1;
      check("rr_no_rsp", 64'(rsp_valid), 64'd0);
    end
    check("rr_no_access", 64'(t_acc.size()), 64'(n0));
    check("rr_req_ready_back", 64'(req_ready), 64'd1);
    rd(7'h20);

    repeat (2) @(posedge clk0);
    #1;
    check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
